// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_tb_pkg
// Description : Shared types and constants for the slave-side AXI write
//               responder: B response codes and the entry layouts of the
//               AW request queue and the B response queue.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_tb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // IDs are stored at a fixed maximum width so the entry types can live in
    // the package; instances use the low AXI_ID_W bits (AXI_ID_W <= 16).
    localparam int c_ID_MAX_W = 16;

    typedef struct packed {
        logic [c_ID_MAX_W-1:0] id;
        logic [7:0]            len;
    } aw_entry_t;

    typedef struct packed {
        logic [c_ID_MAX_W-1:0] id;
        logic [1:0]            resp;
    } b_entry_t;

endpackage
`default_nettype wire

// File: rtl/axi_slv_wr_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_slv_wr_responder_if
// Description : AW / W / B channel bundle between a write master (or bench
//               driver) and the slave-side write responder.
//               master modport : drives in_* (AW, W, bready), reads out_*
//               slave modport  : reads in_*, drives out_* (awready, wready, B)
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_slv_wr_responder_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    // AW channel
    logic                    in_awvalid;
    logic                    out_awready;
    logic [AXI_ID_W-1:0]     in_awid;
    logic [7:0]              in_awlen;
    // W channel
    logic                    in_wvalid;
    logic                    out_wready;
    logic [AXI_ID_W-1:0]     in_wid;
    logic [AXI_DATA_W-1:0]   in_wdata;
    logic [AXI_DATA_W/8-1:0] in_wstrb;
    logic                    in_wlast;
    // B channel
    logic                    out_bvalid;
    logic                    in_bready;
    logic [AXI_ID_W-1:0]     out_bid;
    logic [1:0]              out_bresp;

    modport master (
        output in_awvalid, in_awid, in_awlen,
        output in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast,
        output in_bready,
        input  out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );

    modport slave (
        input  in_awvalid, in_awid, in_awlen,
        input  in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast,
        input  in_bready,
        output out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_cnt
// Description : Single-clock FIFO with an occupancy counter one bit wider
//               than the pointers (full vs. empty). Head is shown
//               combinationally from storage. Push while full and pop while
//               empty are ignored; simultaneous push and pop are both taken.
//               DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// Ports       : aclk, aresetn (async active-low)
//               i_push/i_din, i_pop, o_full, o_empty, o_head
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_cnt #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire               aclk,
    input  wire               aresetn,
    input  wire               i_push,
    input  wire [WIDTH-1:0]   i_din,
    input  wire               i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [WIDTH-1:0]  o_head
);
    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: o_empty qualifies every read of the head.
    always_ff @(posedge aclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_slv_wr_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_slv_wr_responder
// Description : Slave-side AXI write responder. Queues AW requests, consumes
//               W beats in AW order checking each burst against the queued
//               length and ID, and returns one B response per burst (OKAY or
//               SLVERR) through a response queue, strictly in AW order.
// Ports       : aclk, aresetn    clock, async active-low reset
//               bus (slave)      AW / W / B channels
//               stall_w          external backpressure, forces wready low
//               out_err_cnt      saturating count of SLVERR responses issued
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slv_wr_responder
    import axi_tb_pkg::*;
#(
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int SLV_OSTDREQ_NUM = 4,
    parameter int ERR_CNT_W       = 16
) (
    input  wire                   aclk,
    input  wire                   aresetn,
    axi_slv_wr_responder_if.slave bus,
    input  wire                   stall_w,
    output logic [ERR_CNT_W-1:0]  out_err_cnt
);
    // ------------------------------------------------------------------
    // Queue interconnect
    // ------------------------------------------------------------------
    aw_entry_t w_aw_din;
    aw_entry_t w_aw_head;
    logic      w_aw_full;
    logic      w_aw_empty;
    logic      w_aw_push;

    b_entry_t  w_b_din;
    b_entry_t  w_b_head;
    logic      w_b_full;
    logic      w_b_empty;
    logic      w_b_push;
    logic      w_b_pop;

    // ------------------------------------------------------------------
    // Burst tracking state
    // ------------------------------------------------------------------
    logic                 r_run;        // low in reset, high from first edge after
    logic [8:0]           r_beat_cnt;
    logic                 r_err;        // sticky error for the burst in progress
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_w_hs;
    logic w_len_hit;
    logic w_short;
    logic w_id_bad;
    logic w_beat_err;
    logic w_burst_end;
    logic w_burst_err;

    // W payload is sunk; head ID bits above AXI_ID_W never reach the port.
    logic [AXI_DATA_W+AXI_DATA_W/8-1:0] w_unused_w_payload;
    logic [c_ID_MAX_W-1:0]              w_unused_b_id;

    assign w_unused_w_payload = {bus.in_wdata, bus.in_wstrb};
    assign w_unused_b_id      = w_b_head.id;

    // ------------------------------------------------------------------
    // AW channel
    // ------------------------------------------------------------------
    assign bus.out_awready = r_run && !w_aw_full;
    assign w_aw_push       = bus.in_awvalid && bus.out_awready;
    assign w_aw_din        = '{id: c_ID_MAX_W'(bus.in_awid), len: bus.in_awlen};

    sync_fifo_cnt #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (SLV_OSTDREQ_NUM)
    ) u_aw_q (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (w_aw_push),
        .i_din   (w_aw_din),
        .i_pop   (w_b_push),
        .o_full  (w_aw_full),
        .o_empty (w_aw_empty),
        .o_head  (w_aw_head)
    );

    // ------------------------------------------------------------------
    // W channel: only beats whose AW is already queued are accepted, and
    // only when the B queue has room for the response the beat may finish.
    // ------------------------------------------------------------------
    assign bus.out_wready = !w_aw_empty && !w_b_full && !stall_w;
    assign w_w_hs         = bus.in_wvalid && bus.out_wready;

    assign w_len_hit   = (r_beat_cnt == {1'b0, w_aw_head.len});
    assign w_short     = bus.in_wlast && (r_beat_cnt < {1'b0, w_aw_head.len});
    assign w_id_bad    = (c_ID_MAX_W'(bus.in_wid) != w_aw_head.id);
    assign w_beat_err  = w_short || (!bus.in_wlast && w_len_hit) || w_id_bad;
    // A missing wlast forces the end at the AW length; later beats start
    // the next burst.
    assign w_burst_end = bus.in_wlast || w_len_hit;
    assign w_burst_err = r_err || w_beat_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run      <= 1'b0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_w_hs) begin
                if (w_burst_end) begin
                    r_beat_cnt <= '0;
                    r_err      <= 1'b0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 9'd1;
                    r_err      <= w_burst_err;
                end
            end
            if (w_b_push && w_burst_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_err_cnt = r_err_cnt;

    // ------------------------------------------------------------------
    // B channel: the burst-ending beat pops the AW head and pushes its
    // response in the same cycle.
    // ------------------------------------------------------------------
    assign w_b_push = w_w_hs && w_burst_end;
    assign w_b_din  = '{id: w_aw_head.id, resp: (w_burst_err ? RESP_SLVERR : RESP_OKAY)};
    assign w_b_pop  = bus.out_bvalid && bus.in_bready;

    sync_fifo_cnt #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (SLV_OSTDREQ_NUM)
    ) u_b_q (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (w_b_push),
        .i_din   (w_b_din),
        .i_pop   (w_b_pop),
        .o_full  (w_b_full),
        .o_empty (w_b_empty),
        .o_head  (w_b_head)
    );

    // Head only moves on a pop, so ID/resp stay stable while stalled.
    assign bus.out_bvalid = !w_b_empty;
    assign bus.out_bid    = w_b_empty ? '0 : w_b_head.id[AXI_ID_W-1:0];
    assign bus.out_bresp  = w_b_empty ? RESP_OKAY : w_b_head.resp;

endmodule
`default_nettype wire
